ps2_rx: RTL and testbench

Parametrised PS/2-style serial receiver for the keyboard front end, and the successor to the fixed 8-bit parser. It samples an asynchronous device clock/data pair on `sysclk` and deframes start/data/parity/stop. Completed words go into a small show-ahead FIFO with a valid/ready handshake. Framing faults are reported as one-cycle error pulses and the receiver recovers on its own; it never halts the simulation.

---
 rtl/ps2_rx.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ps2_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: parametrised PS/2-style serial receiver.
// Synchronises the asynchronous device clock/data pair onto sysclk, removes
// short clock glitches, deframes start/data/parity/stop on each falling edge
// of the filtered clock, and delivers completed words through a show-ahead
// FIFO with a valid/ready handshake. Framing faults and FIFO overflow are
// reported as registered one-cycle pulses; the receiver always self-recovers.

module ps2_rx #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 4,
  parameter int TIMEOUT     = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 dat,
  output logic [DATA_BITS-1:0] word,
  output logic                 valid,
  input  logic                 ready,
  output logic                 err_start,
  output logic                 err_parity,
  output logic                 err_stop,
  output logic                 err_timeout,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int FLT_W = $clog2(FILTER + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PRTY = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  // True when the received parity bit matches the configured parity mode.
  function automatic logic parity_good(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY == 2) begin
      parity_good = ~x;
    end else begin
      parity_good = x;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Synchroniser and glitch filter
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fclk_r;
  logic                   fclk_d_r;
  logic [FLT_W-1:0]       flt_cnt_r;
  logic                   sample_s;

  assign clk_s    = clk_sync_r[SYNC_STAGES-1];
  assign dat_s    = dat_sync_r[SYNC_STAGES-1];
  // One sample event per accepted 1->0 transition of the filtered clock.
  assign sample_s = fclk_d_r & ~fclk_r;

  // Shift the raw lines through the synchroniser chains; idle-high after reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], clk};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], dat};
    end
  end

  // Accept a new clock level only after it has held for FILTER cycles.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      fclk_r    <= 1'b1;
      fclk_d_r  <= 1'b1;
      flt_cnt_r <= {FLT_W{1'b0}};
    end else begin
      fclk_d_r <= fclk_r;
      if (clk_s == fclk_r) begin
        flt_cnt_r <= {FLT_W{1'b0}};
      end else if (flt_cnt_r == FLT_W'(FILTER - 1)) begin
        fclk_r    <= clk_s;
        flt_cnt_r <= {FLT_W{1'b0}};
      end else begin
        flt_cnt_r <= flt_cnt_r + {{(FLT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Deframing FSM with watchdog
  // ---------------------------------------------------------------------
  logic [1:0]           state_r,   state_n;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg_r,   shreg_n;
  logic                 bad_r,     bad_n;
  logic [WD_W-1:0]      wd_r,      wd_n;
  logic                 push_s;
  logic                 e_start_s, e_par_s, e_stop_s, e_tmo_s;
  logic                 err_start_r, err_parity_r, err_stop_r, err_timeout_r;

  // Next-state, framing checks and watchdog decisions for the current cycle.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shreg_n   = shreg_r;
    bad_n     = bad_r;
    wd_n      = wd_r;
    push_s    = 1'b0;
    e_start_s = 1'b0;
    e_par_s   = 1'b0;
    e_stop_s  = 1'b0;
    e_tmo_s   = 1'b0;
    if (sample_s) begin
      wd_n = {WD_W{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (!dat_s) begin
            state_n   = ST_DATA;
            bit_cnt_n = {CNT_W{1'b0}};
            bad_n     = 1'b0;
          end else begin
            e_start_s = 1'b1;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so each new bit enters at the MSB end.
          shreg_n   = {dat_s, shreg_r[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (bit_cnt_r == CNT_W'(DATA_BITS - 1)) begin
            state_n = (PARITY == 0) ? ST_STOP : ST_PRTY;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_PRTY: begin
          if (!parity_good(shreg_r, dat_s)) begin
            e_par_s = 1'b1;
            bad_n   = 1'b1;
          end else begin
            bad_n   = bad_r;
          end
          // Always consume the stop slot so it is never taken as a start bit.
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (bad_r) begin
            push_s = 1'b0;
          end else if (dat_s) begin
            push_s = 1'b1;
          end else begin
            e_stop_s = 1'b1;
          end
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else if (state_r != ST_IDLE) begin
      if (wd_r == WD_W'(TIMEOUT - 1)) begin
        wd_n    = {WD_W{1'b0}};
        e_tmo_s = 1'b1;
        state_n = ST_IDLE;
      end else begin
        wd_n = wd_r + {{(WD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      wd_n = {WD_W{1'b0}};
    end
  end

  // FSM state, shift register, watchdog and registered error pulses.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {CNT_W{1'b0}};
      shreg_r       <= {DATA_BITS{1'b0}};
      bad_r         <= 1'b0;
      wd_r          <= {WD_W{1'b0}};
      err_start_r   <= 1'b0;
      err_parity_r  <= 1'b0;
      err_stop_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      bit_cnt_r     <= bit_cnt_n;
      shreg_r       <= shreg_n;
      bad_r         <= bad_n;
      wd_r          <= wd_n;
      err_start_r   <= e_start_s;
      err_parity_r  <= e_par_s;
      err_stop_r    <= e_stop_s;
      err_timeout_r <= e_tmo_s;
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead output FIFO with registered head
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_r, rd_ptr_n;
  logic [PTR_W-1:0]     wr_ptr_r, wr_ptr_n;
  logic [OCC_W-1:0]     occ_r,    occ_n;
  logic [OCC_W-1:0]     remain_s;
  logic [DATA_BITS-1:0] head_n;
  logic [DATA_BITS-1:0] word_r;
  logic                 valid_r;
  logic                 overflow_r;
  logic                 pop_s, full_s, wr_en_s, ovf_s;

  assign pop_s   = valid_r & ready;
  assign full_s  = (occ_r == OCC_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign ovf_s   = push_s & full_s & ~pop_s;

  // Pointer/occupancy update and the head value visible next cycle.
  always_comb begin
    rd_ptr_n = rd_ptr_r;
    wr_ptr_n = wr_ptr_r;
    occ_n    = occ_r;
    remain_s = occ_r - OCC_W'(pop_s);
    head_n   = {DATA_BITS{1'b0}};
    if (pop_s) begin
      rd_ptr_n = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_n = rd_ptr_r;
    end
    if (wr_en_s) begin
      wr_ptr_n = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_n = wr_ptr_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   occ_n = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
      2'b01:   occ_n = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
      default: occ_n = occ_r;
    endcase
    // When nothing older remains, the word being pushed becomes the head.
    if (occ_n == {OCC_W{1'b0}}) begin
      head_n = {DATA_BITS{1'b0}};
    end else if (remain_s == {OCC_W{1'b0}}) begin
      head_n = shreg_r;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge sysclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= shreg_r;
    end
  end

  // FIFO control state and registered head/valid/overflow outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {OCC_W{1'b0}};
      word_r     <= {DATA_BITS{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_n;
      wr_ptr_r   <= wr_ptr_n;
      occ_r      <= occ_n;
      word_r     <= head_n;
      valid_r    <= (occ_n != {OCC_W{1'b0}});
      overflow_r <= ovf_s;
    end
  end

  assign word        = word_r;
  assign valid       = valid_r;
  assign err_start   = err_start_r;
  assign err_parity  = err_parity_r;
  assign err_stop    = err_stop_r;
  assign err_timeout = err_timeout_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx.
// A cycle-stamped schedule of expected events (computed from frame contents
// and the documented sample latency) drives a queue-based FIFO model that is
// compared against the default-configuration DUT on every cycle. A second
// instance (9 data bits, no parity) is checked with literal expectations.

module tb_ps2_rx;

  localparam int DB = 8;
  localparam int S  = 2;
  localparam int F  = 4;
  localparam int TO = 2000;
  localparam int D  = 4;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic          reset, rclk, rdat, ready;
  logic [DB-1:0] word;
  logic          valid, err_start, err_parity, err_stop, err_timeout, overflow;

  logic          reset2, rclk2, rdat2, ready2;
  logic [8:0]    word2;
  logic          valid2, e2_start, e2_parity, e2_stop, e2_timeout, ovf2;

  ps2_rx #(.DATA_BITS(DB), .PARITY(1), .SYNC_STAGES(S), .FILTER(F),
           .TIMEOUT(TO), .FIFO_DEPTH(D)) dut (
    .sysclk(sysclk), .reset(reset), .clk(rclk), .dat(rdat),
    .word(word), .valid(valid), .ready(ready),
    .err_start(err_start), .err_parity(err_parity), .err_stop(err_stop),
    .err_timeout(err_timeout), .overflow(overflow));

  ps2_rx #(.DATA_BITS(9), .PARITY(0)) dut2 (
    .sysclk(sysclk), .reset(reset2), .clk(rclk2), .dat(rdat2),
    .word(word2), .valid(valid2), .ready(ready2),
    .err_start(e2_start), .err_parity(e2_parity), .err_stop(e2_stop),
    .err_timeout(e2_timeout), .overflow(ovf2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit rnd_ready = 1'b0;

  // Expected-event codes: [4] start err, [3] parity err, [2] stop err,
  // [1] timeout, [0] push of exp_data.
  logic [4:0]    exp_code [int];
  logic [DB-1:0] exp_data [int];
  logic [DB-1:0] mq [$];
  logic [4:0]    e_vec = 5'b0;
  logic [4:0]    code;
  bit            pop;

  logic [DB-1:0] popped [$];
  int vcnt = 0, n_start = 0, n_par = 0, n_stop = 0, n_tmo = 0, n_ovf = 0;
  int n_err2 = 0;

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Reference model: advance the expected FIFO and pulses at every edge.
  always @(posedge sysclk) begin
    cyc++;
    started = 1'b1;
    if (reset) begin
      mq.delete();
      e_vec = 5'b0;
    end else begin
      pop  = (mq.size() != 0) && ready;
      code = exp_code.exists(cyc) ? exp_code[cyc] : 5'b0;
      if (pop) void'(mq.pop_front());
      e_vec = {code[4:1], 1'b0};
      if (code[0]) begin
        if (mq.size() < D) mq.push_back(exp_data[cyc]);
        else e_vec[0] = 1'b1;
      end
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge sysclk) begin
    if (started) begin
      checks++;
      if (valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL valid cyc=%0d got=%b expected=%b", cyc, valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if (word !== mq[0]) begin
          errors++;
          $display("FAIL word cyc=%0d got=%h expected=%h", cyc, word, mq[0]);
        end
      end
      checks++;
      if ({err_start, err_parity, err_stop, err_timeout, overflow} !== e_vec) begin
        errors++;
        $display("FAIL pulses cyc=%0d got=%b expected=%b", cyc,
                 {err_start, err_parity, err_stop, err_timeout, overflow}, e_vec);
      end
      if (valid === 1'b1 && ready === 1'b1) popped.push_back(word);
      if (valid === 1'b1) vcnt++;
      n_start += int'(err_start);
      n_par   += int'(err_parity);
      n_stop  += int'(err_stop);
      n_tmo   += int'(err_timeout);
      n_ovf   += int'(overflow);
      n_err2  += int'(e2_start | e2_parity | e2_stop | e2_timeout | ovf2);
    end
  end

  // Randomised consumer back-pressure during the random phase.
  always @(posedge sysclk) begin
    if (rnd_ready) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  // One device-clock bit on DUT 1; schedules the expectation for its sample edge.
  task automatic pulse_bit(input logic d, input int hp, input logic [4:0] c,
                           input logic [DB-1:0] data, output int se);
    rdat = d;
    tick(2);
    rclk = 1'b0;
    se = cyc + 1 + S + F;
    if (c != 5'b0) begin
      exp_code[se] = c;
      exp_data[se] = data;
    end
    tick(hp);
    rclk = 1'b1;
    tick(hp);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input logic stopb, input int hp);
    int   se;
    logic p;
    pulse_bit(1'b0, hp, 5'b0, 8'h00, se);
    for (int i = 0; i < DB; i++) pulse_bit(d[i], hp, 5'b0, 8'h00, se);
    p = odd_par(d) ^ logic'(bad_par);
    pulse_bit(p, hp, bad_par ? 5'b01000 : 5'b00000, d, se);
    pulse_bit(stopb, hp, bad_par ? 5'b00000 : (stopb ? 5'b00001 : 5'b00100), d, se);
    rdat = 1'b1;
  endtask

  task automatic pulse2(input logic d, input int hp);
    rdat2 = d;
    tick(2);
    rclk2 = 1'b0;
    tick(hp);
    rclk2 = 1'b1;
    tick(hp);
  endtask

  // Frame on DUT 2; nbits < 9 sends only a partial frame.
  task automatic send2(input logic [8:0] d, input int nbits);
    pulse2(1'b0, 7);
    for (int i = 0; i < nbits; i++) pulse2(d[i], 7);
    if (nbits == 9) pulse2(1'b1, 7);
    rdat2 = 1'b1;
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int se, np, k0, v0, s0, p0, t0, o0;
    logic [7:0] rd;
    reset = 1'b1; rclk = 1'b1; rdat = 1'b1; ready = 1'b1;
    reset2 = 1'b1; rclk2 = 1'b1; rdat2 = 1'b1; ready2 = 1'b0;
    tick(4);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_word", {24'b0, word}, 32'd0);
    chk("reset_pulses", {27'b0, err_start, err_parity, err_stop, err_timeout, overflow}, 32'd0);
    reset = 1'b0; reset2 = 1'b0;
    tick(5);

    chk("model_par_1C", {31'b0, odd_par(8'h1C)}, 32'd0);
    chk("model_par_F0", {31'b0, odd_par(8'hF0)}, 32'd1);

    // Clean frame 0x1C.
    np = popped.size(); v0 = vcnt; k0 = n_start + n_par + n_stop + n_tmo + n_ovf;
    send_frame(8'h1C, 1'b0, 1'b1, 8);
    tick(20);
    chk("clean_pops", popped.size() - np, 32'd1);
    chk("clean_word", {24'b0, popped[popped.size()-1]}, 32'h1C);
    chk("clean_valid_cycles", vcnt - v0, 32'd1);
    chk("clean_no_err", n_start + n_par + n_stop + n_tmo + n_ovf - k0, 32'd0);

    // Bad parity, then good 0xF0.
    np = popped.size(); p0 = n_par;
    send_frame(8'h1C, 1'b1, 1'b1, 8);
    send_frame(8'hF0, 1'b0, 1'b1, 8);
    tick(20);
    chk("parity_pulses", n_par - p0, 32'd1);
    chk("parity_pops", popped.size() - np, 32'd1);
    chk("parity_next_word", {24'b0, popped[popped.size()-1]}, 32'hF0);

    // Clock stalls high after 4 data bits.
    t0 = n_tmo; np = popped.size();
    pulse_bit(1'b0, 8, 5'b0, 8'h00, se);
    for (int i = 0; i < 4; i++) pulse_bit(1'(8'hA3 >> i), 8, 5'b0, 8'h00, se);
    exp_code[se + TO] = 5'b00010;
    rdat = 1'b1;
    tick(TO + 10);
    send_frame(8'h5A, 1'b0, 1'b1, 8);
    tick(20);
    chk("timeout_pulses", n_tmo - t0, 32'd1);
    chk("timeout_recover", {24'b0, popped[popped.size()-1]}, 32'h5A);

    // Overflow with ready low, then drain.
    ready = 1'b0; o0 = n_ovf;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 6);
    tick(10);
    chk("ovf_pulses", n_ovf - o0, 32'd1);
    chk("ovf_valid_held", {31'b0, valid}, 32'd1);
    np = popped.size();
    ready = 1'b1;
    tick(12);
    chk("ovf_drain_count", popped.size() - np, 32'd4);
    for (int i = 0; i < 4; i++) chk("ovf_drain_order", {24'b0, popped[np+i]}, 32'(i + 1));

    // Glitch of FILTER-1 cycles in idle, then a full frame.
    s0 = n_start; np = popped.size();
    rclk = 1'b0;
    tick(F - 1);
    rclk = 1'b1;
    tick(12);
    send_frame(8'h3C, 1'b0, 1'b1, 8);
    tick(20);
    chk("glitch_no_start_err", n_start - s0, 32'd0);
    chk("glitch_frame", {24'b0, popped[popped.size()-1]}, 32'h3C);

    // Start slot sampled high, stop error, and minimum half-period frame.
    s0 = n_start;
    pulse_bit(1'b1, 8, 5'b10000, 8'h00, se);
    tick(5);
    chk("start_err", n_start - s0, 32'd1);
    s0 = n_stop;
    send_frame(8'h77, 1'b0, 1'b0, 8);
    tick(5);
    chk("stop_err", n_stop - s0, 32'd1);
    send_frame(8'h81, 1'b0, 1'b1, F + 1);
    tick(20);
    chk("min_half_period", {24'b0, popped[popped.size()-1]}, 32'h81);

    // Randomised frames with random back-pressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int kind, hp;
      kind = $urandom_range(0, 9);
      hp   = $urandom_range(F + 1, 10);
      rd   = 8'($urandom);
      if (kind == 0) pulse_bit(1'b1, hp, 5'b10000, 8'h00, se);
      else send_frame(rd, kind == 1, (kind == 2) ? 1'b0 : 1'b1, hp);
      tick($urandom_range(0, 6));
    end
    rnd_ready = 1'b0;
    tick(1);
    ready = 1'b1;
    tick(30);
    chk("final_drained", {31'b0, valid}, 32'd0);

    // Alternate configuration: 9 data bits, no parity.
    send2(9'h1A5, 9);
    tick(10);
    chk("alt_valid", {31'b0, valid2}, 32'd1);
    chk("alt_word", {23'b0, word2}, 32'h1A5);
    send2(9'h0F3, 3);
    reset2 = 1'b1;
    tick(2);
    reset2 = 1'b0;
    tick(3);
    chk("alt_reset_valid", {31'b0, valid2}, 32'd0);
    chk("alt_reset_word", {23'b0, word2}, 32'h0);
    send2(9'h0F3, 9);
    tick(10);
    chk("alt_after_reset_valid", {31'b0, valid2}, 32'd1);
    chk("alt_after_reset_word", {23'b0, word2}, 32'h0F3);
    chk("alt_no_pulses", n_err2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
